// File: rtl/syscall_unit.sv
// Syscall handler: halts fetch on the halt code, publishes a0 on the display code,
// and counts accepted syscalls and running cycles. Registered outputs, except pc_en.
module syscall_unit #(
  parameter logic [31:0] HALT_CODE = 32'd10,
  parameter logic [31:0] DISP_CODE = 32'd34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sys,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  input  logic        resume,
  output logic        pc_en,
  output logic        halt,
  output logic [31:0] disp_data,
  output logic        disp_valid,
  output logic [15:0] sys_count,
  output logic [31:0] run_cycles
);

  typedef enum logic [1:0] {RUN, HALTED, RESUME} state_t;

  state_t      state_q, state_d;
  logic        resume_prev_q, resume_prev_d;
  logic        halt_q, halt_d;
  logic [31:0] disp_data_q, disp_data_d;
  logic        disp_valid_q, disp_valid_d;
  logic [15:0] sys_count_q, sys_count_d;
  logic [31:0] run_cycles_q, run_cycles_d;

  logic accept;
  logic is_halt;
  logic resume_edge;

  always_comb begin
    accept        = (state_q == RUN) && sys;
    is_halt       = (v0 == HALT_CODE);
    resume_edge   = resume && !resume_prev_q;
    resume_prev_d = resume;
    state_d       = state_q;
    disp_data_d   = disp_data_q;
    disp_valid_d  = 1'b0;
    sys_count_d   = sys_count_q;

    // Same-cycle hold on a halt syscall keeps the PC at the syscall itself.
    pc_en = ((state_q == RUN) && !(sys && is_halt)) || (state_q == RESUME);

    unique case (state_q)
      RUN:     if (accept && is_halt) state_d = HALTED;
      HALTED:  if (resume_edge) state_d = RESUME;
      RESUME:  state_d = RUN;
      default: state_d = RUN;
    endcase

    if (accept && (v0 == DISP_CODE)) begin
      disp_data_d  = a0;
      disp_valid_d = 1'b1;
    end

    if (accept && (sys_count_q != 16'hFFFF)) sys_count_d = sys_count_q + 16'd1;

    run_cycles_d = pc_en ? run_cycles_q + 32'd1 : run_cycles_q;
    halt_d       = (state_d == HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      resume_prev_q <= 1'b0;
      halt_q        <= 1'b0;
      disp_data_q   <= 32'd0;
      disp_valid_q  <= 1'b0;
      sys_count_q   <= 16'd0;
      run_cycles_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      resume_prev_q <= resume_prev_d;
      halt_q        <= halt_d;
      disp_data_q   <= disp_data_d;
      disp_valid_q  <= disp_valid_d;
      sys_count_q   <= sys_count_d;
      run_cycles_q  <= run_cycles_d;
    end
  end

  assign halt       = halt_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign sys_count  = sys_count_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: display, halt/resume, no-op, saturation, wrap, async reset.
module tb_syscall_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sys = 1'b0;
  logic [31:0] v0 = 32'd0;
  logic [31:0] a0 = 32'd0;
  logic        resume = 1'b0;
  logic        pc_en;
  logic        halt;
  logic [31:0] disp_data;
  logic        disp_valid;
  logic [15:0] sys_count;
  logic [31:0] run_cycles;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_rc = 32'd0;

  syscall_unit dut (
    .clk(clk), .rst(rst), .sys(sys), .v0(v0), .a0(a0), .resume(resume),
    .pc_en(pc_en), .halt(halt), .disp_data(disp_data), .disp_valid(disp_valid),
    .sys_count(sys_count), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Present inputs, check combinational pc_en, then advance one clock and settle.
  task automatic step(input logic s, input logic [31:0] v, input logic [31:0] a,
                      input logic exp_pc, input string tag);
    sys = s; v0 = v; a0 = a;
    #1;
    chk(tag, {31'd0, pc_en}, {31'd0, exp_pc});
    if (exp_pc) exp_rc = exp_rc + 32'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_disp_data", disp_data, 32'd0);
    chk("rst_disp_valid", {31'd0, disp_valid}, 32'd0);
    chk("rst_sys_count", {16'd0, sys_count}, 32'd0);
    chk("rst_run_cycles", run_cycles, 32'd0);
    chk("rst_pc_en", {31'd0, pc_en}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_rc = 32'd0;

    // Display syscall
    step(1'b1, 32'd34, 32'hDEADBEEF, 1'b1, "disp_pc_en");
    chk("disp_data", disp_data, 32'hDEADBEEF);
    chk("disp_valid_pulse", {31'd0, disp_valid}, 32'd1);
    chk("disp_sys_count", {16'd0, sys_count}, 32'd1);
    chk("disp_halt", {31'd0, halt}, 32'd0);
    chk("disp_run_cycles", run_cycles, exp_rc);
    step(1'b0, 32'd0, 32'd0, 1'b1, "idle_pc_en");
    chk("disp_valid_drop", {31'd0, disp_valid}, 32'd0);
    chk("disp_data_hold", disp_data, 32'hDEADBEEF);

    // Halt syscall, then 20 halted cycles with ignored syscalls presented
    step(1'b1, 32'd10, 32'h0, 1'b0, "halt_pc_en");
    chk("halt_set", {31'd0, halt}, 32'd1);
    chk("halt_sys_count", {16'd0, sys_count}, 32'd2);
    for (int i = 0; i < 20; i++) step(1'b1, 32'd34, 32'h1111_1111, 1'b0, "halted_pc_en");
    chk("halted_halt", {31'd0, halt}, 32'd1);
    chk("halted_run_cycles", run_cycles, exp_rc);
    chk("halted_run_cycles_abs", run_cycles, 32'd2);
    chk("halted_sys_count", {16'd0, sys_count}, 32'd2);
    chk("halted_disp_data", disp_data, 32'hDEADBEEF);
    chk("halted_disp_valid", {31'd0, disp_valid}, 32'd0);

    // Resume held high for 10 cycles yields one RESUME cycle
    resume = 1'b1;
    step(1'b0, 32'd0, 32'd0, 1'b0, "edge_cycle_pc_en");
    chk("resume_halt_clear", {31'd0, halt}, 32'd0);
    step(1'b1, 32'd10, 32'd0, 1'b1, "resume_cycle_pc_en");
    chk("resume_sys_ignored", {16'd0, sys_count}, 32'd2);
    chk("resume_no_halt", {31'd0, halt}, 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 32'd0, 1'b1, "resume_held_pc_en");
    chk("resume_held_halt", {31'd0, halt}, 32'd0);
    chk("resume_run_cycles", run_cycles, exp_rc);
    chk("resume_run_cycles_abs", run_cycles, 32'd11);
    resume = 1'b0;

    // Unknown code is a no-op
    step(1'b1, 32'd5, 32'hCAFE_0000, 1'b1, "noop_pc_en");
    chk("noop_sys_count", {16'd0, sys_count}, 32'd3);
    chk("noop_disp_valid", {31'd0, disp_valid}, 32'd0);
    chk("noop_halt", {31'd0, halt}, 32'd0);
    chk("noop_disp_data", disp_data, 32'hDEADBEEF);

    // Resume edge while running has no effect
    resume = 1'b1;
    step(1'b0, 32'd0, 32'd0, 1'b1, "run_resume_pc_en");
    chk("run_resume_halt", {31'd0, halt}, 32'd0);
    resume = 1'b0;
    chk("run_resume_rc", run_cycles, 32'd13);

    // Reset asserted while halted
    step(1'b1, 32'd10, 32'd0, 1'b0, "halt2_pc_en");
    step(1'b0, 32'd0, 32'd0, 1'b0, "halt2_idle_pc_en");
    chk("halt2_halt", {31'd0, halt}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_halt", {31'd0, halt}, 32'd0);
    chk("mid_rst_disp_data", disp_data, 32'd0);
    chk("mid_rst_sys_count", {16'd0, sys_count}, 32'd0);
    chk("mid_rst_run_cycles", run_cycles, 32'd0);
    chk("mid_rst_pc_en", {31'd0, pc_en}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_rc = 32'd0;
    step(1'b0, 32'd0, 32'd0, 1'b1, "post_rst_pc_en");
    chk("post_rst_halt", {31'd0, halt}, 32'd0);
    chk("post_rst_rc", run_cycles, 32'd1);

    // sys_count saturation across 65537 accepted syscalls
    sys = 1'b1; v0 = 32'd5; a0 = 32'd0;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", {16'd0, sys_count}, 32'h0000_FFFE);
    @(posedge clk);
    #1;
    chk("sat_ffff", {16'd0, sys_count}, 32'h0000_FFFF);
    repeat (2) @(posedge clk);
    #1;
    chk("sat_hold", {16'd0, sys_count}, 32'h0000_FFFF);
    chk("sat_run_cycles", run_cycles, 32'd65538);
    sys = 1'b0;

    // run_cycles wrap from a preloaded value
    dut.run_cycles_q = 32'hFFFF_FFFE;
    exp_rc = 32'hFFFF_FFFE;
    step(1'b0, 32'd0, 32'd0, 1'b1, "wrap1_pc_en");
    chk("wrap_max", run_cycles, 32'hFFFF_FFFF);
    step(1'b0, 32'd0, 32'd0, 1'b1, "wrap2_pc_en");
    chk("wrap_zero", run_cycles, 32'd0);
    chk("wrap_model", run_cycles, exp_rc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/syscall_unit.md
SYSCALL_UNIT -- requirements
Module: syscall_unit

Interface
REQ-001 The block SHALL use one clock `clk` and an asynchronous, active-high reset `rst`.
REQ-002 Port list, in this order:
- clk  input  1  rising-edge clock
- rst  input  1  async active-high reset
- sys  input  1  decoded syscall flag for the instruction currently in execute
- v0  input  32  register $2 read value, valid whenever sys=1
- a0  input  32  register $4 read value, valid whenever sys=1
- resume  input  1  debounced level from the run button
- pc_en  output  1  PC/fetch advance enable (combinational)
- halt  output  1  machine halted indicator (registered)
- disp_data  output  32  last value published by a display syscall (registered)
- disp_valid  output  1  one-cycle pulse when disp_data updates (registered)
- sys_count  output  16  accepted syscall count (registered)
- run_cycles  output  32  count of cycles with pc_en=1 (registered)
REQ-003 Parameters, one per line:
- HALT_CODE, default 10, v0 value meaning halt
- DISP_CODE, default 34, v0 value meaning display a0

Function
REQ-004 The FSM SHALL have exactly three states: RUN, HALTED, RESUME.
REQ-005 A syscall SHALL be accepted in a cycle when state=RUN and sys=1; the block SHALL ignore sys in HALTED and RESUME.
REQ-006 Accepted, v0==HALT_CODE: pc_en=0 in that same cycle (combinational, so the syscall PC is held), next state HALTED.
REQ-007 Accepted, v0==DISP_CODE: disp_data<=a0, disp_valid=1 for the next cycle only, pc_en=1, state stays RUN.
REQ-008 Accepted, any other v0 value: no-op, pc_en=1, state stays RUN.
REQ-009 pc_en SHALL equal (state==RUN && !(sys && v0==HALT_CODE)) || state==RESUME.
REQ-010 HALTED: pc_en=0, halt=1; a rising edge of resume SHALL move the FSM to RESUME.
REQ-011 Rising-edge detection: a 1-bit register holds the previous resume; edge = resume && !prev. The register SHALL update every cycle in every state.
REQ-012 RESUME lasts exactly one cycle: pc_en=1 so the PC steps past the halting syscall, sys is ignored, next state RUN.
REQ-013 halt SHALL be 1 exactly while state==HALTED.
REQ-014 A resume edge while in RUN or RESUME SHALL have no effect; holding resume high SHALL produce only one RESUME.
REQ-015 sys_count SHALL increment by 1 per accepted syscall (REQ-006/007/008 alike) and saturate at 16'hFFFF.
REQ-016 run_cycles SHALL increment by 1 in every cycle with pc_en=1 and wrap modulo 2^32.
REQ-017 disp_data SHALL hold its value until the next display syscall; a halt syscall SHALL NOT alter it.

Reset
REQ-018 rst=1 SHALL immediately force: state=RUN, halt=0, disp_data=0, disp_valid=0, sys_count=0, run_cycles=0, resume edge register=0.
REQ-019 Reset asserted in HALTED or RESUME SHALL return the FSM to RUN; pc_en SHALL be 1 on the first cycle after release unless a halt syscall is presented.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then sys=1, v0=34, a0=32'hDEADBEEF for one cycle -> next cycle disp_data=DEADBEEF, disp_valid=1 for exactly one cycle, sys_count=1, pc_en never 0.
- sys=1, v0=10 -> pc_en=0 in the same cycle; halt=1 from the next cycle; pc_en stays 0 and run_cycles stays frozen for 20 cycles.
- Halted, resume held high 10 cycles -> exactly one RESUME cycle with pc_en=1, then RUN, halt=0; sys=1, v0=10 presented during the RESUME cycle is ignored.
- sys=1, v0=5 -> no display pulse, no halt, sys_count increments.
- 65537 accepted syscalls -> sys_count=FFFF; run_cycles preloaded near FFFFFFFF wraps to 0.
- rst asserted mid-HALTED -> all outputs reset asynchronously; after release, state=RUN and pc_en=1.
